adc_frame_source: RTL and testbench

Trigger-aligned sample frame producer on the clkSmpl domain. It captures the decimated ADC stream into a double-banked frame memory with pre-trigger history. It serves completed frames sample-by-sample to the display sample consumer over the `smpl_req` / `smpl` interface. This block is the producing end of the interface the sparse-samples renderer reads from its sample FIFO.

---
 rtl/adc_frame_source_if.sv | 28 ++
 rtl/adc_frame_source.sv | 198 +++++++++++++++++++
 tb/tb_adc_frame_source.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_source_if.sv
// adc_frame_source_if
// Sample readout link between the frame source and the display sample
// consumer. The consumer raises smpl_req (a level, sampled every clkSmpl
// edge). The source answers with one registered sample per requesting edge.
//   smpl_req    : consumer -> source, request one sample this edge
//   smpl        : source -> consumer, 10-bit sample
//   smpl_first  : source -> consumer, smpl holds index 0 of a frame
//   trig_forced : source -> consumer, frame being read was auto-triggered
interface adc_frame_source_if;
    logic       smpl_req;
    logic [9:0] smpl;
    logic       smpl_first;
    logic       trig_forced;

    modport master (
        input  smpl_req,
        output smpl,
        output smpl_first,
        output trig_forced
    );

    modport slave (
        output smpl_req,
        input  smpl,
        input  smpl_first,
        input  trig_forced
    );
endinterface

// File: rtl/adc_frame_source.sv
// adc_frame_source
// Captures the decimated ADC stream into one bank of a double-banked frame
// memory. Each frame holds PRE samples of pre-trigger history. Completed
// frames are served sample-by-sample from the other bank. A frame is never
// torn: banks swap only when the reader is idle (nothing valid yet) or has
// just issued the last index of the current frame.
// Ports:
//   clkSmpl    : sample clock, all logic on rising edge
//   n_reset    : asynchronous active-low reset
//   adc        : 10-bit unsigned sample, qualified by adc_valid
//   trig_level : trigger threshold
//   trig_fall  : 0 = rising-edge trigger, 1 = falling-edge trigger
//   trig_auto  : force a trigger after AUTO_TO samples spent armed
//   smpl_bus   : readout link (smpl_req in; smpl, smpl_first, trig_forced out)
module adc_frame_source #(
    parameter int DEPTH   = 512,
    parameter int PRE     = 128,
    parameter int AUTO_TO = 4096
) (
    input  logic                      clkSmpl,
    input  logic                      n_reset,
    input  logic [9:0]                adc,
    input  logic                      adc_valid,
    input  logic [9:0]                trig_level,
    input  logic                      trig_fall,
    input  logic                      trig_auto,
    adc_frame_source_if.master        smpl_bus
);
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_ARM  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } cap_state_t;

    localparam int AW     = $clog2(DEPTH);
    localparam int ACW    = $clog2(AUTO_TO + 1);
    localparam int POST_N = DEPTH - PRE - 1;

    localparam logic [AW-1:0]  PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0]  POST_LAST = AW'(POST_N - 1);
    localparam logic [AW-1:0]  PRE_OFS   = AW'(PRE);
    localparam logic [AW-1:0]  IDX_LAST  = AW'(DEPTH - 1);
    localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_TO - 1);
    // With PRE = DEPTH-1 there is nothing to write after the trigger sample.
    localparam cap_state_t TRIG_NEXT = (POST_N == 0) ? ST_DONE : ST_POST;

    logic [9:0]     mem_r [2*DEPTH];

    cap_state_t     state_r;
    logic [AW-1:0]  wr_addr_r;
    logic [AW-1:0]  cnt_r;
    logic [ACW-1:0] auto_cnt_r;
    logic [9:0]     prev_r;
    logic [AW-1:0]  start_r;
    logic           forced_r;

    logic           rd_bank_r;
    logic           rd_valid_r;
    logic [AW-1:0]  rd_idx_r;
    logic [AW-1:0]  start_rd_r;
    logic [9:0]     smpl_r;
    logic           smpl_first_r;
    logic           trig_forced_r;

    logic           cap_bank_s;
    logic           trig_hit_s;
    logic           auto_hit_s;
    logic           wr_en_s;
    logic           rd_fire_s;
    logic           swap_s;
    logic [AW-1:0]  rd_addr_s;

    // The capture bank is always the bank not being read.
    assign cap_bank_s = ~rd_bank_r;

    assign smpl_bus.smpl        = smpl_r;
    assign smpl_bus.smpl_first  = smpl_first_r;
    assign smpl_bus.trig_forced = trig_forced_r;

    // Trigger detection, write enable, readout request and bank-swap decode.
    always_comb begin
        trig_hit_s = 1'b0;
        if (trig_fall) begin
            trig_hit_s = (prev_r > trig_level) && (adc <= trig_level);
        end else begin
            trig_hit_s = (prev_r < trig_level) && (adc >= trig_level);
        end
        auto_hit_s = trig_auto && (auto_cnt_r >= AUTO_LAST);
        wr_en_s    = adc_valid && (state_r != ST_DONE);
        rd_fire_s  = smpl_bus.smpl_req && rd_valid_r;
        // Swap immediately when nothing is being shown, otherwise only on
        // the edge that issues the last sample of the current frame.
        swap_s     = (state_r == ST_DONE) &&
                     (!rd_valid_r || (smpl_bus.smpl_req && (rd_idx_r == IDX_LAST)));
        rd_addr_s  = start_rd_r + rd_idx_r;
    end

    // Frame memory write port; contents need no reset since rd_valid gates reads.
    always_ff @(posedge clkSmpl) begin
        if (wr_en_s) begin
            mem_r[{cap_bank_s, wr_addr_r}] <= adc;
        end
    end

    // Capture FSM: pre-trigger fill, armed ring, post-trigger fill, wait for swap.
    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            state_r    <= ST_FILL;
            wr_addr_r  <= {AW{1'b0}};
            cnt_r      <= {AW{1'b0}};
            auto_cnt_r <= {ACW{1'b0}};
            prev_r     <= 10'd0;
            start_r    <= {AW{1'b0}};
            forced_r   <= 1'b0;
        end else begin
            if (adc_valid) begin
                prev_r <= adc;
            end
            case (state_r)
                ST_FILL: begin
                    if (adc_valid) begin
                        wr_addr_r <= wr_addr_r + AW'(1);
                        if (cnt_r == PRE_LAST) begin
                            cnt_r      <= {AW{1'b0}};
                            auto_cnt_r <= {ACW{1'b0}};
                            state_r    <= ST_ARM;
                        end else begin
                            cnt_r <= cnt_r + AW'(1);
                        end
                    end
                end
                ST_ARM: begin
                    if (adc_valid) begin
                        wr_addr_r <= wr_addr_r + AW'(1);
                        if (trig_hit_s || auto_hit_s) begin
                            // Frame starts PRE samples before the trigger sample.
                            start_r  <= wr_addr_r - PRE_OFS;
                            forced_r <= !trig_hit_s;
                            cnt_r    <= {AW{1'b0}};
                            state_r  <= TRIG_NEXT;
                        end else if (auto_cnt_r < AUTO_LAST) begin
                            auto_cnt_r <= auto_cnt_r + ACW'(1);
                        end
                    end
                end
                ST_POST: begin
                    if (adc_valid) begin
                        wr_addr_r <= wr_addr_r + AW'(1);
                        if (cnt_r == POST_LAST) begin
                            state_r <= ST_DONE;
                        end else begin
                            cnt_r <= cnt_r + AW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (swap_s) begin
                        wr_addr_r <= {AW{1'b0}};
                        cnt_r     <= {AW{1'b0}};
                        state_r   <= ST_FILL;
                    end
                end
                default: begin
                    state_r <= ST_FILL;
                end
            endcase
        end
    end

    // Readout: registered memory output, frame index and bank swap.
    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            rd_bank_r     <= 1'b0;
            rd_valid_r    <= 1'b0;
            rd_idx_r      <= {AW{1'b0}};
            start_rd_r    <= {AW{1'b0}};
            smpl_r        <= 10'd0;
            smpl_first_r  <= 1'b0;
            trig_forced_r <= 1'b0;
        end else begin
            if (rd_fire_s) begin
                smpl_r       <= mem_r[{rd_bank_r, rd_addr_s}];
                smpl_first_r <= (rd_idx_r == {AW{1'b0}});
                rd_idx_r     <= rd_idx_r + AW'(1);
            end
            // On a last-index swap the final sample above is still read from
            // the old bank; the new frame starts at the next request.
            if (swap_s) begin
                rd_bank_r     <= ~rd_bank_r;
                start_rd_r    <= start_r;
                trig_forced_r <= forced_r;
                rd_idx_r      <= {AW{1'b0}};
                rd_valid_r    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_source.sv
// tb_adc_frame_source
// Randomised bench for adc_frame_source (DEPTH=16, PRE=4, AUTO_TO=8).
// A behavioural model keeps the accepted sample history as a queue, picks the
// trigger position from the threshold rules and slices the frame out of that
// history; the reader is modelled as a frame array plus an index.
module tb_adc_frame_source;
    localparam int DEPTH   = 16;
    localparam int PRE     = 4;
    localparam int AUTO_TO = 8;

    logic       clkSmpl = 1'b0;
    logic       n_reset = 1'b0;
    logic [9:0] adc = 10'd0;
    logic       adc_valid = 1'b0;
    logic [9:0] trig_level = 10'd512;
    logic       trig_fall = 1'b0;
    logic       trig_auto = 1'b0;

    adc_frame_source_if bus ();

    adc_frame_source #(.DEPTH(DEPTH), .PRE(PRE), .AUTO_TO(AUTO_TO)) dut (
        .clkSmpl   (clkSmpl),
        .n_reset   (n_reset),
        .adc       (adc),
        .adc_valid (adc_valid),
        .trig_level(trig_level),
        .trig_fall (trig_fall),
        .trig_auto (trig_auto),
        .smpl_bus  (bus)
    );

    always #5 clkSmpl = ~clkSmpl;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int cap_q[$];
    int trig_pos;
    bit cap_done;
    bit cap_forced;
    int arm_cnt;
    int prev;
    int rd_frame[DEPTH];
    bit rd_valid;
    int rd_idx;
    int exp_smpl;
    int exp_first;
    int exp_forced;

    int got_s[64];
    int got_f[64];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        cap_q.delete();
        trig_pos   = -1;
        cap_done   = 1'b0;
        cap_forced = 1'b0;
        arm_cnt    = 0;
        prev       = 0;
        rd_valid   = 1'b0;
        rd_idx     = 0;
        exp_smpl   = 0;
        exp_first  = 0;
        exp_forced = 0;
        for (int i = 0; i < DEPTH; i++) rd_frame[i] = 0;
    endtask

    task automatic model_step(input bit req, input bit valid, input int v);
        bit swap;
        bit hit;
        int k;
        swap = cap_done && (!rd_valid || (req && rd_idx == DEPTH - 1));
        if (rd_valid && req) begin
            exp_smpl  = rd_frame[rd_idx];
            exp_first = (rd_idx == 0);
            rd_idx    = (rd_idx + 1) % DEPTH;
        end
        if (valid) begin
            if (!cap_done) begin
                cap_q.push_back(v);
                k = cap_q.size() - 1;
                if (trig_pos < 0 && k >= PRE) begin
                    arm_cnt++;
                    if (trig_fall) hit = (prev > int'(trig_level)) && (v <= int'(trig_level));
                    else           hit = (prev < int'(trig_level)) && (v >= int'(trig_level));
                    if (hit) begin
                        trig_pos = k; cap_forced = 1'b0;
                    end else if (trig_auto && arm_cnt >= AUTO_TO) begin
                        trig_pos = k; cap_forced = 1'b1;
                    end
                end
                if (trig_pos >= 0 && k == trig_pos + DEPTH - PRE - 1) cap_done = 1'b1;
            end
            prev = v;
        end
        if (swap) begin
            for (int i = 0; i < DEPTH; i++) rd_frame[i] = cap_q[trig_pos - PRE + i];
            exp_forced = cap_forced;
            rd_valid   = 1'b1;
            rd_idx     = 0;
            cap_q.delete();
            trig_pos   = -1;
            cap_done   = 1'b0;
            arm_cnt    = 0;
        end
    endtask

    task automatic tick(input bit req, input bit valid, input int v);
        bus.smpl_req = req;
        adc_valid    = valid;
        adc          = 10'(v);
        @(posedge clkSmpl);
        model_step(req, valid, v);
        #1;
        chk_val("smpl", 32'(bus.smpl), 32'(exp_smpl));
        chk_val("smpl_first", 32'(bus.smpl_first), 32'(exp_first));
        chk_val("trig_forced", 32'(bus.trig_forced), 32'(exp_forced));
    endtask

    task automatic feed(input int v, input bit req);
        repeat ($urandom_range(0, 2)) tick(req, 1'b0, 0);
        tick(req, 1'b1, v);
    endtask

    task automatic req_run(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 0);
            got_s[i] = int'(bus.smpl);
            got_f[i] = int'(bus.smpl_first);
        end
    endtask

    task automatic do_reset();
        bus.smpl_req = 1'b0;
        adc_valid    = 1'b0;
        n_reset      = 1'b0;
        #1;
        model_reset();
        chk_val("rst_smpl", 32'(bus.smpl), 32'd0);
        chk_val("rst_first", 32'(bus.smpl_first), 32'd0);
        chk_val("rst_forced", 32'(bus.trig_forced), 32'd0);
        @(posedge clkSmpl);
        #1;
        n_reset = 1'b1;
    endtask

    initial begin
        int nfirst;
        model_reset();
        bus.smpl_req = 1'b0;
        @(posedge clkSmpl);
        #1;
        chk_val("rst_smpl", 32'(bus.smpl), 32'd0);
        chk_val("rst_first", 32'(bus.smpl_first), 32'd0);
        chk_val("rst_forced", 32'(bus.trig_forced), 32'd0);
        n_reset = 1'b1;

        // Rising trigger on a ramp
        for (int i = 0; i < 18; i++) feed((i * 100) % 1024, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 0);
        req_run(16);
        for (int i = 0; i < 5; i++) chk_val("ramp_pre", 32'(got_s[i]), 32'(200 + 100 * i));
        nfirst = 0;
        for (int i = 0; i < 16; i++) nfirst += got_f[i];
        chk_val("ramp_first_cnt", 32'(nfirst), 32'd1);
        chk_val("ramp_first0", 32'(got_f[0]), 32'd1);
        chk_val("ramp_forced", 32'(bus.trig_forced), 32'd0);

        // Auto trigger on a flat input
        do_reset();
        trig_auto = 1'b1;
        for (int i = 0; i < 4 + 8 + 11; i++) feed(300, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 0);
        chk_val("auto_forced", 32'(bus.trig_forced), 32'd1);
        req_run(16);
        for (int i = 0; i < 16; i++) chk_val("auto_val", 32'(got_s[i]), 32'd300);
        do_reset();
        trig_auto = 1'b0;
        for (int i = 0; i < 30; i++) feed(300, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 0);
        req_run(10);
        for (int i = 0; i < 10; i++) chk_val("noauto_zero", 32'(got_s[i]), 32'd0);

        // Falling trigger, Fill exclusion, frame repeat
        do_reset();
        trig_fall = 1'b1;
        feed(700, 1'b0); feed(300, 1'b0); feed(700, 1'b0); feed(700, 1'b0);
        feed(700, 1'b0); feed(300, 1'b0);
        for (int i = 0; i < 11; i++) feed($urandom_range(0, 1023), 1'b0);
        repeat (2) tick(1'b0, 1'b0, 0);
        req_run(40);
        chk_val("fall_idx3", 32'(got_s[3]), 32'd700);
        chk_val("fall_idx4", 32'(got_s[4]), 32'd300);
        nfirst = 0;
        for (int i = 0; i < 40; i++) nfirst += got_f[i];
        chk_val("rep_first_cnt", 32'(nfirst), 32'd3);
        chk_val("rep_first1", 32'(got_f[0]), 32'd1);
        chk_val("rep_first17", 32'(got_f[16]), 32'd1);
        chk_val("rep_first33", 32'(got_f[32]), 32'd1);
        // Second frame completes mid-readout; swap waits for index 15
        for (int i = 0; i < 4; i++) feed($urandom_range(0, 1023), 1'b0);
        feed(800, 1'b0); feed(200, 1'b0);
        for (int i = 0; i < 11; i++) feed($urandom_range(0, 1023), 1'b0);
        repeat (3) tick(1'b0, 1'b0, 0);
        req_run(13);
        nfirst = 0;
        for (int i = 0; i < 8; i++) nfirst += got_f[i];
        chk_val("notear_first", 32'(nfirst), 32'd0);
        chk_val("swap_first", 32'(got_f[8]), 32'd1);
        chk_val("swap_trig_idx4", 32'(got_s[12]), 32'd200);

        // Intermittent requests
        for (int r = 0; r < 8; r++) begin
            tick(1'b1, 1'b0, 0); tick(1'b0, 1'b0, 0); tick(1'b1, 1'b0, 0);
            tick(1'b1, 1'b0, 0); tick(1'b0, 1'b0, 0);
        end

        // Random traffic with occasional trigger reconfiguration
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 63) == 0) trig_fall  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) trig_auto  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) trig_level = 10'($urandom_range(200, 800));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 1023));
        end

        // Reset mid-Post, then a fresh frame from Fill
        trig_fall = 1'b0; trig_auto = 1'b0; trig_level = 10'd512;
        do_reset();
        for (int i = 0; i < 9; i++) feed(i * 100, 1'b0);
        do_reset();
        req_run(5);
        for (int i = 0; i < 5; i++) chk_val("post_rst_zero", 32'(got_s[i]), 32'd0);
        feed(100, 1'b0); feed(900, 1'b0); feed(900, 1'b0); feed(900, 1'b0);
        feed(100, 1'b0); feed(600, 1'b0);
        for (int i = 0; i < 11; i++) feed($urandom_range(0, 1023), 1'b0);
        repeat (2) tick(1'b0, 1'b0, 0);
        req_run(16);
        chk_val("fresh_idx0", 32'(got_s[0]), 32'd900);
        chk_val("fresh_idx3", 32'(got_s[3]), 32'd100);
        chk_val("fresh_idx4", 32'(got_s[4]), 32'd600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
